// File: rtl/vga_capture.sv
// vga_capture: VGA receive end; recovers line/frame timing, locks to the mode, streams active pixels
// Ports:
//   pixel_clk, pixel_rst            clock and asynchronous active-high reset
//   vga_r/g/b, vga_hsync, vga_vsync sampled VGA pins (syncs active-low)
//   pix_rgb, pix_x, pix_y           captured pixel {r,g,b} and its coordinates
//   pix_vld, pix_rdy                output stream handshake (no back-pressure to the VGA side)
//   pix_sof, pix_eol                qualify pix_vld: pixel (0,0) / last pixel of a line
//   locked                          timing locked to the expected mode
//   sync_err                        one-cycle pulse on a timing violation while tracking/locked
//   ovf, ovf_clr                    sticky dropped-pixel flag and its clear
module vga_capture #(
    parameter int RSIZE         = 4,
    parameter int GSIZE         = 4,
    parameter int BSIZE         = 4,
    parameter int RGB_SIZE      = RSIZE + GSIZE + BSIZE,
    parameter int H_DISPLAY     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int START_DELAY   = 0,
    parameter int LOCK_FRAMES   = 2
) (
    input  logic                           pixel_clk,
    input  logic                           pixel_rst,
    input  logic [RSIZE-1:0]               vga_r,
    input  logic [GSIZE-1:0]               vga_g,
    input  logic [BSIZE-1:0]               vga_b,
    input  logic                           vga_hsync,
    input  logic                           vga_vsync,
    output logic [RGB_SIZE-1:0]            pix_rgb,
    output logic                           pix_vld,
    input  logic                           pix_rdy,
    output logic                           pix_sof,
    output logic                           pix_eol,
    output logic [$clog2(H_DISPLAY)-1:0]   pix_x,
    output logic [$clog2(V_DISPLAY)-1:0]   pix_y,
    output logic                           locked,
    output logic                           sync_err,
    output logic                           ovf,
    input  logic                           ovf_clr
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW = $clog2(2 * H_TOTAL);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = $clog2(H_DISPLAY);
    localparam int YW = $clog2(V_DISPLAY);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int HA_I = H_SYNC_PULSE + H_BACK_PORCH + START_DELAY;
    localparam int VA_I = V_SYNC_PULSE + V_BACK_PORCH - 1;
    localparam logic [HW-1:0] H_MAX  = HW'(2 * H_TOTAL - 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HA     = HW'(HA_I);
    localparam logic [HW-1:0] HE     = HW'(HA_I + H_DISPLAY - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA     = VW'(VA_I);
    localparam logic [VW-1:0] VE     = VW'(VA_I + V_DISPLAY - 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_DISPLAY - 1);
    localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_LOCK} state_t;

    state_t                state, state_n;
    logic [GW-1:0]         good, good_n;
    logic [RGB_SIZE-1:0]   rgb_d;
    logic                  hs_d, hs_d1, vs_d, vs_d1;
    logic [HW-1:0]         hcnt, hcnt_n;
    logic [VW-1:0]         vcnt, vcnt_n;
    logic                  vs_arm, vs_arm_n, v_seen, v_seen_n;
    logic                  hs_fall, vs_fall, vreset, line_err, frame_err, err, clean, active, emit;
    logic [XW-1:0]         x_n;
    logic [YW-1:0]         y_n;

    // hcnt_n/vcnt_n are the coordinates of the sample currently held in rgb_d,
    // so the registered outputs pair each pixel with its own position.
    always_comb begin
        hs_fall   = hs_d1 & ~hs_d;
        vs_fall   = vs_d1 & ~vs_d;
        vreset    = hs_fall & (vs_arm | vs_fall);
        hcnt_n    = hs_fall ? '0 : (hcnt == H_MAX) ? hcnt : hcnt + 1'b1;
        vcnt_n    = vreset ? '0 : (hs_fall && vcnt != '1) ? vcnt + 1'b1 : vcnt;
        vs_arm_n  = vreset ? 1'b0 : (vs_arm | vs_fall);
        line_err  = (hs_fall && hcnt != H_LAST) || hcnt == H_MAX;
        // The first frame boundary after losing sync has no valid previous count.
        frame_err = vreset & v_seen & (vcnt != V_LAST);
        clean     = vreset & v_seen & (vcnt == V_LAST);
        err       = line_err | frame_err;
        active    = hcnt_n >= HA && hcnt_n <= HE && vcnt_n >= VA && vcnt_n <= VE;
        emit      = active & (state == S_LOCK);
        x_n       = XW'(hcnt_n - HA);
        y_n       = YW'(vcnt_n - VA);
    end

    always_comb begin
        state_n = state;
        good_n  = good;
        if (state == S_SEARCH) begin
            state_n = hs_fall ? S_TRACK : S_SEARCH;
        end else if (err) begin
            state_n = S_SEARCH;
            good_n  = '0;
        end else if (state == S_TRACK && clean) begin
            good_n  = good + 1'b1;
            state_n = (good_n == G_LOCK) ? S_LOCK : S_TRACK;
        end
        v_seen_n = (state_n == S_SEARCH) ? 1'b0 : (v_seen | vreset);
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= S_SEARCH;
            good  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            rgb_d    <= '0;
            hs_d     <= 1'b0;
            hs_d1    <= 1'b0;
            vs_d     <= 1'b0;
            vs_d1    <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            vs_arm   <= 1'b0;
            v_seen   <= 1'b0;
            sync_err <= 1'b0;
            pix_vld  <= 1'b0;
            pix_sof  <= 1'b0;
            pix_eol  <= 1'b0;
            pix_rgb  <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            ovf      <= 1'b0;
        end else begin
            rgb_d    <= {vga_r, vga_g, vga_b};
            hs_d     <= vga_hsync;
            hs_d1    <= hs_d;
            vs_d     <= vga_vsync;
            vs_d1    <= vs_d;
            hcnt     <= hcnt_n;
            vcnt     <= vcnt_n;
            vs_arm   <= vs_arm_n;
            v_seen   <= v_seen_n;
            sync_err <= err & (state != S_SEARCH);
            pix_vld  <= emit;
            pix_sof  <= emit & (x_n == '0) & (y_n == '0);
            pix_eol  <= emit & (x_n == X_LAST);
            pix_rgb  <= emit ? rgb_d : pix_rgb;
            pix_x    <= emit ? x_n : pix_x;
            pix_y    <= emit ? y_n : pix_y;
            // A drop in the same cycle as the clear keeps the flag set.
            ovf      <= (pix_vld & ~pix_rdy) | (ovf & ~ovf_clr);
        end
    end

    assign locked = (state == S_LOCK);
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized scoreboard bench for vga_capture on a reduced video mode
module tb_vga_capture;
    localparam int H_DISP = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_DISP = 6, V_FP = 1, V_SYNC = 1, V_BP = 3;
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync;
    logic [11:0] pix_rgb;
    logic        pix_vld, pix_rdy, pix_sof, pix_eol;
    logic [3:0]  pix_x;
    logic [2:0]  pix_y;
    logic        locked, sync_err, ovf, ovf_clr;

    vga_capture #(
        .H_DISPLAY(H_DISP), .H_FRONT_PORCH(H_FP), .H_SYNC_PULSE(H_SYNC), .H_BACK_PORCH(H_BP),
        .V_DISPLAY(V_DISP), .V_FRONT_PORCH(V_FP), .V_SYNC_PULSE(V_SYNC), .V_BACK_PORCH(V_BP)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .pix_rgb(pix_rgb), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_x(pix_x), .pix_y(pix_y),
        .locked(locked), .sync_err(sync_err), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          errors = 0;
    int          checks = 0;
    int          lock_frame = 2;
    int          mode = 0;
    bit          rand_clr = 1'b1;
    int          exp_sync = 0;
    int          sync_seen = 0;
    bit          sync_prev = 1'b0;
    bit          exp_ovf = 1'b0;
    logic [20:0] q[$];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    // Lock is expected from the frame boundary (line 1) of lock_frame onward.
    function automatic bit lock_exp(input int f, input int line);
        return f > lock_frame || (f == lock_frame && line >= 1);
    endfunction

    task automatic cyc(input int f, input int line, input int c, input bit idle);
        int          pos, x, y;
        logic [11:0] rgb;
        @(posedge pixel_clk);
        #1;
        pos = line * H_TOTAL + c;
        vga_hsync = idle ? 1'b1 : (c >= H_SYNC);
        vga_vsync = idle ? 1'b1 : !(pos >= 1 && pos <= V_SYNC * H_TOTAL);
        rgb = 12'($urandom);
        {vga_r, vga_g, vga_b} = rgb;
        x = c - (H_SYNC + H_BP);
        y = line - (V_SYNC + V_BP);
        if (!idle && x >= 0 && x < H_DISP && y >= 0 && y < V_DISP && lock_exp(f, line))
            q.push_back({rgb, 4'(x), 3'(y), 1'(x == 0 && y == 0), 1'(x == H_DISP - 1)});
        case (mode)
            1: {pix_rdy, ovf_clr} = 2'b01;
            2: {pix_rdy, ovf_clr} = 2'b11;
            3: {pix_rdy, ovf_clr} = 2'b00;
            default: begin
                pix_rdy = ($urandom_range(15) != 0);
                ovf_clr = rand_clr && ($urandom_range(31) == 0);
            end
        endcase
        if (!idle && c == H_TOTAL / 2) chk("locked", locked, lock_exp(f, line));
    endtask

    task automatic do_reset(input int f);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_ovf", ovf, 1);
        #2 pixel_rst = 1'b1;
        #1;
        chk("rst_pix_vld", pix_vld, 0);
        chk("rst_locked", locked, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sync_err", sync_err, 0);
        pixel_rst = 1'b0;
        lock_frame = f + 3;
    endtask

    initial begin
        forever begin
            @(negedge pixel_clk or posedge pixel_rst);
            if (pixel_rst) begin
                exp_ovf = 1'b0;
                sync_prev = 1'b0;
                continue;
            end
            chk("ovf", ovf, exp_ovf);
            if (pix_vld) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix_vld: got 1 expected 0 (no pixel due) at %0t", $time);
                end else chk("pixel{rgb,x,y,sof,eol}", {pix_rgb, pix_x, pix_y, pix_sof, pix_eol}, q.pop_front());
            end else chk("sof_eol_without_vld", {pix_sof, pix_eol}, 0);
            if (sync_err) begin
                sync_seen++;
                chk("sync_err_width", sync_prev, 0);
            end
            sync_prev = sync_err;
            exp_ovf = (pix_vld & ~pix_rdy) | (exp_ovf & ~ovf_clr);
        end
    end

    initial begin
        pixel_rst = 1'b1;
        {vga_r, vga_g, vga_b} = '0;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        pix_rdy = 1'b1;
        ovf_clr = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("reset_pix_vld", pix_vld, 0);
        chk("reset_locked", locked, 0);
        chk("reset_sync_err", sync_err, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_sof_eol", {pix_sof, pix_eol}, 0);
        chk("reset_pix_rgb", pix_rgb, 0);
        chk("reset_pix_xy", {pix_x, pix_y}, 0);
        pixel_rst = 1'b0;
        // Long idle lets hcnt saturate while searching, which must not pulse sync_err.
        for (int i = 0; i < 60; i++) cyc(0, 0, 0, 1);
        for (int f = 0; f < 21; f++) begin
            for (int line = 0; line < V_TOTAL; line++) begin
                int len;
                mode = (f == 4 && line == 5) ? 1 : (f == 4 && line == 6) ? 2 : (f == 14 && line == 5) ? 3 : 0;
                rand_clr = (f < 12);
                len = (f == 5 && line == 6) ? H_TOTAL - 1 : H_TOTAL;
                for (int c = 0; c < len; c++) begin
                    cyc(f, line, c, 0);
                    if (f == 15 && line == 6 && c == 2) do_reset(f);
                end
                if (len != H_TOTAL) begin
                    lock_frame = f + 3;
                    exp_sync++;
                end
                if (f == 10 && line == 5) begin
                    for (int i = 0; i < 2 * H_TOTAL + 10; i++) cyc(f, line, 0, 1);
                    lock_frame = f + 3;
                    exp_sync++;
                    break;
                end
            end
        end
        mode = 0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        chk("pixels_outstanding", q.size(), 0);
        chk("sync_err_pulses", sync_seen, exp_sync);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
